dpic_mem_master: RTL and testbench
==================================

Name: dpic_mem_master

Overview:
- Pipeline-side initiator for the DPI-C backed simulation memory: accepts one load/store request at a time, drives the memory's read/write port, and returns aligned, sign/zero-extended load data.
- Sits between the LSU/EXU stage and the DPI memory model. It is a blocking single-outstanding-transaction FSM.

Parameters:
- ADDR_W, 64, request/memory address width. The data path is fixed at 64 bits.

Ports:
- clk  in  1  clock, all state updates on posedge
- rst  in  1  asynchronous reset, active-high
- req_valid  in  1  request valid
- req_ready  out  1  master can accept a request
- req_wen  in  1  1 = store, 0 = load
- req_size  in  2  0=byte, 1=half, 2=word, 3=double
- req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend
- req_addr  in  ADDR_W  byte address
- req_wdata  in  64  store data, right-justified
- resp_valid  out  1  response valid
- resp_ready  in  1  consumer accepts response
- resp_rdata  out  64  extended load data; 0 for stores and errors
- resp_err  out  1  misaligned access, no memory access performed
- mem_rd_en  out  1  read strobe; memory samples it at posedge and returns mem_rd_data after that edge
- mem_rd_addr  out  ADDR_W  8-byte-aligned read address
- mem_rd_data  in  64  read data, valid the cycle after the sampling edge
- mem_we_en  out  1  write strobe, exactly one cycle per store
- mem_we_addr  out  ADDR_W  unaligned byte address of the store
- mem_we_data  out  64  store data, right-justified, unshifted
- mem_we_mask  out  8  low-justified size mask

Behaviour:
- Reset (async, immediate): state=IDLE. All outputs are 0 except req_ready, which is 1 once rst deasserts. Any in-flight transaction is dropped, and read data already returned by memory is discarded.
- FSM states: IDLE, WRITE, READ, RD_WAIT, RESP.
- IDLE: req_ready=1. Acceptance is req_valid&req_ready at a posedge (edge E0).
  - Misaligned request (addr mod 2^size != 0): go to RESP with resp_err=1 and resp_rdata=0. mem_rd_en and mem_we_en are never asserted.
  - Aligned store: register mem_we_addr=req_addr, mem_we_data=req_wdata, and mem_we_mask per size (0:0x01, 1:0x03, 2:0x0F, 3:0xFF). Go to WRITE.
  - Aligned load: register mem_rd_addr=req_addr with bits[2:0] cleared, and latch offset=req_addr[2:0], size, and signed. Go to READ.
- WRITE: mem_we_en=1 for exactly one cycle. All mem_we_* come from registers and change only at clock edges, so there are no combinational glitches (the model writes combinationally). Next state is RESP with resp_rdata=0 and resp_err=0.
- READ: mem_rd_en=1 for one cycle. The memory samples at edge E1. Next state is RD_WAIT.
- RD_WAIT: mem_rd_en=0. At edge E2, extract the lane: shift mem_rd_data right by offset*8, truncate to the size width, then sign- or zero-extend to 64 bits. Register the result into resp_rdata and go to RESP.
- RESP: resp_valid=1, and resp_rdata/resp_err are held stable. On resp_valid&resp_ready, go to IDLE and clear resp_rdata/resp_err. req_ready=0 in every state except IDLE.
- Latency from acceptance edge to resp_valid high:
  - load: 3 cycles (READ, RD_WAIT, RESP)
  - store: 2 cycles (WRITE, RESP)
  - error: 1 cycle (RESP)
- Size 3 loads use offset 0 only (alignment guaranteed), so no extension is applied.
- mem_rd_addr and mem_we_addr/data/mask keep their last values between transactions. The strobes alone qualify them.
- Back-to-back requests: a new request is accepted in the cycle after the response handshake. No overlap.

Test Plan:
- Reset -> with rst=1 asserted mid-cycle, all outputs go to 0 immediately; after release, req_ready=1 and no mem strobes appear.
- SD addr 0x80000010, wdata 0x1122334455667788 -> mem_we_en high exactly 1 cycle with mem_we_addr=0x80000010, mask=0xFF, data=0x1122334455667788; resp_valid 2 cycles after accept; err=0; rdata=0.
- LB signed addr 0x80000013, mem_rd_data=0x0123456789ABCDEF -> mem_rd_en 1 cycle with mem_rd_addr=0x80000010, resp_rdata=0xFFFFFFFFFFFFFF89. The same request unsigned gives 0x0000000000000089.
- LH signed addr 0x8000001A and LW signed addr 0x8000001C, same data -> 0xFFFFFFFFFFFF89AB and 0x0000000001234567. SH at 0x80000002 with wdata 0xBEEF -> mask 0x03, data 0xBEEF.
- LW addr 0x80000002 -> no mem_rd_en or mem_we_en; resp_valid 1 cycle after accept with resp_err=1, rdata=0.
- Backpressure: resp_ready low 3 cycles after a load response -> resp_valid and resp_rdata held constant, req_ready=0 while a competing req_valid is held. After the handshake, the next request is accepted one cycle later. Async rst asserted in RD_WAIT -> IDLE, and no response is issued.

Source files
------------

// File: rtl/dpic_mem_master_if.sv
// Request/response and memory-port bundle for dpic_mem_master.
//   req_*   : one load/store request from the LSU/EXU (valid/ready)
//   resp_*  : load data / error back to the pipeline (valid/ready)
//   mem_rd_*: read port of the DPI-C memory (sampled at posedge, data next cycle)
//   mem_we_*: write port of the DPI-C memory (one-cycle strobe)
// modport master: the initiator (dpic_mem_master); modport slave: everything around it.
interface dpic_mem_master_if #(
    parameter int unsigned ADDR_W = 64
);
    localparam int unsigned DATA_W = 64;
    localparam int unsigned MASK_W = 8;

    logic              req_valid;
    logic              req_ready;
    logic              req_wen;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;

    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;

    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic [DATA_W-1:0] mem_rd_data;

    logic              mem_we_en;
    logic [ADDR_W-1:0] mem_we_addr;
    logic [DATA_W-1:0] mem_we_data;
    logic [MASK_W-1:0] mem_we_mask;

    modport master (
        input  req_valid, req_wen, req_size, req_signed, req_addr, req_wdata,
        output req_ready,
        output resp_valid, resp_rdata, resp_err,
        input  resp_ready,
        output mem_rd_en, mem_rd_addr,
        input  mem_rd_data,
        output mem_we_en, mem_we_addr, mem_we_data, mem_we_mask
    );

    modport slave (
        output req_valid, req_wen, req_size, req_signed, req_addr, req_wdata,
        input  req_ready,
        input  resp_valid, resp_rdata, resp_err,
        output resp_ready,
        input  mem_rd_en, mem_rd_addr,
        output mem_rd_data,
        input  mem_we_en, mem_we_addr, mem_we_data, mem_we_mask
    );
endinterface

// File: rtl/dpic_mem_master.sv
// Single-outstanding load/store initiator for the DPI-C simulation memory.
// Accepts one request in IDLE, performs a one-cycle write or a read with
// one cycle of memory latency, and returns lane-extracted, sign/zero-extended
// load data. Misaligned requests are answered with resp_err and never touch memory.
// Ports:
//   clk  : clock, all state on posedge
//   rst  : asynchronous active-high reset
//   bus  : dpic_mem_master_if.master (request, response and memory ports)
module dpic_mem_master #(
    parameter int unsigned ADDR_W = 64
) (
    input  logic                clk,
    input  logic                rst,
    dpic_mem_master_if.master   bus
);
    localparam int unsigned DATA_W = 64;
    localparam int unsigned MASK_W = 8;
    localparam int unsigned OFF_W  = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_RD_WAIT,
        S_RESP
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [OFF_W-1:0]  ld_off;
    logic [1:0]        ld_size;
    logic              ld_signed;

    logic              misaligned_c;
    logic [MASK_W-1:0] size_mask_c;
    logic [DATA_W-1:0] shifted_c;
    logic [DATA_W-1:0] lane_c;

    // Natural-alignment check: low log2(size) address bits must be zero.
    always_comb begin
        misaligned_c = 1'b0;
        case (bus.req_size)
            2'd0:    misaligned_c = 1'b0;
            2'd1:    misaligned_c = bus.req_addr[0];
            2'd2:    misaligned_c = |bus.req_addr[1:0];
            default: misaligned_c = |bus.req_addr[2:0];
        endcase
    end

    // Low-justified byte mask for the store size.
    always_comb begin
        size_mask_c = MASK_W'(8'h00);
        case (bus.req_size)
            2'd0:    size_mask_c = MASK_W'(8'h01);
            2'd1:    size_mask_c = MASK_W'(8'h03);
            2'd2:    size_mask_c = MASK_W'(8'h0F);
            default: size_mask_c = MASK_W'(8'hFF);
        endcase
    end

    // Load lane extraction: bring the addressed bytes down, then extend.
    always_comb begin
        shifted_c = bus.mem_rd_data >> {ld_off, 3'b000};
        lane_c    = shifted_c;
        case (ld_size)
            2'd0:    lane_c = {{56{ld_signed & shifted_c[7]}},  shifted_c[7:0]};
            2'd1:    lane_c = {{48{ld_signed & shifted_c[15]}}, shifted_c[15:0]};
            2'd2:    lane_c = {{32{ld_signed & shifted_c[31]}}, shifted_c[31:0]};
            default: lane_c = shifted_c;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (bus.req_valid) begin
                    if (misaligned_c) begin
                        state_nxt = S_RESP;
                    end else if (bus.req_wen) begin
                        state_nxt = S_WRITE;
                    end else begin
                        state_nxt = S_READ;
                    end
                end
            end
            S_WRITE:   state_nxt = S_RESP;
            S_READ:    state_nxt = S_RD_WAIT;
            S_RD_WAIT: state_nxt = S_RESP;
            S_RESP: begin
                if (bus.resp_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default:   state_nxt = S_IDLE;
        endcase
    end

    // Strobes and handshakes decoded from the state register; req_ready is
    // additionally held low while reset is asserted.
    always_comb begin
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        bus.mem_rd_en  = 1'b0;
        bus.mem_we_en  = 1'b0;
        case (state)
            S_IDLE:  bus.req_ready  = ~rst;
            S_WRITE: bus.mem_we_en  = 1'b1;
            S_READ:  bus.mem_rd_en  = 1'b1;
            S_RESP:  bus.resp_valid = 1'b1;
            default: ;
        endcase
    end

    // Request capture, load result and response registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.resp_rdata  <= '0;
            bus.resp_err    <= 1'b0;
            bus.mem_rd_addr <= '0;
            bus.mem_we_addr <= '0;
            bus.mem_we_data <= '0;
            bus.mem_we_mask <= '0;
            ld_off          <= '0;
            ld_size         <= '0;
            ld_signed       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        if (misaligned_c) begin
                            bus.resp_err   <= 1'b1;
                            bus.resp_rdata <= '0;
                        end else if (bus.req_wen) begin
                            bus.mem_we_addr <= bus.req_addr;
                            bus.mem_we_data <= bus.req_wdata;
                            bus.mem_we_mask <= size_mask_c;
                        end else begin
                            bus.mem_rd_addr <= {bus.req_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
                            ld_off          <= bus.req_addr[OFF_W-1:0];
                            ld_size         <= bus.req_size;
                            ld_signed       <= bus.req_signed;
                        end
                    end
                end
                S_RD_WAIT: begin
                    bus.resp_rdata <= lane_c;
                end
                S_RESP: begin
                    if (bus.resp_ready) begin
                        bus.resp_rdata <= '0;
                        bus.resp_err   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_dpic_mem_master.sv
// Directed bench for dpic_mem_master with a transaction-level reference model
// and a per-cycle output compare.
module tb_dpic_mem_master;
    localparam int unsigned ADDR_W = 64;

    logic clk;
    logic rst;

    dpic_mem_master_if #(.ADDR_W(ADDR_W)) bus ();

    dpic_mem_master #(.ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    task automatic check64(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got 0x%h required 0x%h", name, got, exp);
    endtask

    // ---------------- memory model ----------------
    logic [63:0] rd_word = 64'h0;
    logic        rd_pend = 1'b0;
    int          rd_cnt = 0;
    int          we_cnt = 0;
    logic [63:0] last_rd_addr = 64'h0;
    logic [63:0] last_we_addr = 64'h0;
    logic [63:0] last_we_data = 64'h0;
    logic [7:0]  last_we_mask = 8'h0;

    always @(negedge clk) begin
        rd_pend <= bus.mem_rd_en;
        if (bus.mem_rd_en) begin
            rd_cnt++;
            last_rd_addr = bus.mem_rd_addr;
        end
        if (bus.mem_we_en) begin
            we_cnt++;
            last_we_addr = bus.mem_we_addr;
            last_we_data = bus.mem_we_data;
            last_we_mask = bus.mem_we_mask;
        end
    end

    always @(posedge clk) begin
        if (rd_pend) bus.mem_rd_data <= rd_word;
    end

    // ---------------- reference model ----------------
    function automatic logic [63:0] model_load(input logic [63:0] word, input logic [63:0] addr,
                                               input logic [1:0] size, input logic sgn);
        int          nbits;
        int          off;
        logic [63:0] v;
        logic [63:0] keep;
        nbits = 8 << size;
        off   = int'(addr % 8);
        v     = word >> (8 * off);
        if (nbits < 64) begin
            keep = (64'd1 << nbits) - 64'd1;
            v    = v & keep;
            if (sgn && v[nbits-1]) v = v | ~keep;
        end
        return v;
    endfunction

    logic        m_busy = 1'b0;
    int          m_t = 0;
    int          m_lat = 1;
    logic        m_wen = 1'b0;
    logic        m_err = 1'b0;
    logic [1:0]  m_size = 2'd0;
    logic [63:0] m_addr = 64'h0;
    logic [63:0] m_wdata = 64'h0;
    logic [63:0] m_rdata = 64'h0;

    // m_t counts edges since acceptance; outputs are a function of it and the latency.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy = 1'b0;
            m_t    = 0;
        end else if (!m_busy) begin
            if (bus.req_valid) begin
                m_busy  = 1'b1;
                m_t     = 1;
                m_wen   = bus.req_wen;
                m_size  = bus.req_size;
                m_addr  = bus.req_addr;
                m_wdata = bus.req_wdata;
                m_err   = (bus.req_addr % (64'd1 << bus.req_size)) != 64'd0;
                if (m_err) begin
                    m_lat = 1; m_rdata = 64'h0;
                end else if (m_wen) begin
                    m_lat = 2; m_rdata = 64'h0;
                end else begin
                    m_lat = 3; m_rdata = model_load(rd_word, bus.req_addr, bus.req_size, bus.req_signed);
                end
            end
        end else if (m_t >= m_lat) begin
            if (bus.resp_ready) m_busy = 1'b0;
        end else begin
            m_t++;
        end
    end

    logic chk_en = 1'b0;

    always @(negedge clk) begin
        if (chk_en) begin
            logic       e_ready, e_rv, e_we, e_rd;
            logic [7:0] e_mask;
            e_ready = !rst && !m_busy;
            e_rv    = m_busy && (m_t >= m_lat);
            e_we    = m_busy && m_wen && !m_err && (m_t == 1);
            e_rd    = m_busy && !m_wen && !m_err && (m_t == 1);
            e_mask  = 8'((1 << (1 << m_size)) - 1);
            check64("cyc req_ready",  64'(bus.req_ready),  64'(e_ready));
            check64("cyc resp_valid", 64'(bus.resp_valid), 64'(e_rv));
            check64("cyc mem_we_en",  64'(bus.mem_we_en),  64'(e_we));
            check64("cyc mem_rd_en",  64'(bus.mem_rd_en),  64'(e_rd));
            check64("cyc resp_rdata", bus.resp_rdata, e_rv ? m_rdata : 64'h0);
            check64("cyc resp_err",   64'(bus.resp_err),   64'(e_rv && m_err));
            if (e_we) begin
                check64("cyc mem_we_addr", bus.mem_we_addr, m_addr);
                check64("cyc mem_we_data", bus.mem_we_data, m_wdata);
                check64("cyc mem_we_mask", 64'(bus.mem_we_mask), 64'(e_mask));
            end
            if (e_rd) check64("cyc mem_rd_addr", bus.mem_rd_addr, m_addr & ~64'h7);
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic wen, input logic [1:0] size, input logic sgn,
                         input logic [63:0] addr, input logic [63:0] wdata);
        bus.req_wen    = wen;
        bus.req_size   = size;
        bus.req_signed = sgn;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        bus.req_valid  = 1'b1;
    endtask

    // Present a request and return just after its acceptance edge.
    task automatic send(input logic wen, input logic [1:0] size, input logic sgn,
                        input logic [63:0] addr, input logic [63:0] wdata, output int waited);
        drive(wen, size, sgn, addr, wdata);
        waited = 0;
        @(negedge clk);
        while (!bus.req_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.req_ready) check64("accept timeout", 64'(bus.req_ready), 64'd1);
        @(posedge clk);
        #1;
    endtask

    // Wait for the response, compare against literals, optionally stall, then handshake.
    task automatic collect(input string name, input logic [63:0] exp_rdata, input logic exp_err,
                           input int exp_lat, input int stall);
        int k;
        k = 1;
        while (!bus.resp_valid && k < 10) begin
            @(posedge clk);
            #1;
            k++;
        end
        check64({name, " latency"}, 64'(k), 64'(exp_lat));
        check64({name, " rdata"}, bus.resp_rdata, exp_rdata);
        check64({name, " err"}, 64'(bus.resp_err), 64'(exp_err));
        for (int i = 0; i < stall; i++) begin
            @(posedge clk);
            #1;
            check64({name, " held valid"}, 64'(bus.resp_valid), 64'd1);
            check64({name, " held rdata"}, bus.resp_rdata, exp_rdata);
            check64({name, " held req_ready"}, 64'(bus.req_ready), 64'd0);
        end
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.resp_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int rd0, we0;
        bus.req_valid  = 1'b0;
        bus.req_wen    = 1'b0;
        bus.req_size   = 2'd0;
        bus.req_signed = 1'b0;
        bus.req_addr   = 64'h0;
        bus.req_wdata  = 64'h0;
        bus.resp_ready = 1'b0;
        rst = 1'b0;
        #1 rst = 1'b1;
        #1;
        check64("reset req_ready",  64'(bus.req_ready),  64'd0);
        check64("reset resp_valid", 64'(bus.resp_valid), 64'd0);
        check64("reset mem_rd_en",  64'(bus.mem_rd_en),  64'd0);
        check64("reset mem_we_en",  64'(bus.mem_we_en),  64'd0);
        check64("reset resp_rdata", bus.resp_rdata, 64'h0);
        check64("reset resp_err",   64'(bus.resp_err),   64'd0);
        @(posedge clk);
        #3 rst = 1'b0;
        #1 check64("post-reset req_ready", 64'(bus.req_ready), 64'd1);
        chk_en = 1'b1;
        @(posedge clk);
        #1;

        // SD
        we0 = we_cnt;
        send(1'b1, 2'd3, 1'b0, 64'h80000010, 64'h1122334455667788, w);
        bus.req_valid = 1'b0;
        collect("sd", 64'h0, 1'b0, 2, 0);
        check64("sd we count", 64'(we_cnt - we0), 64'd1);
        check64("sd we addr", last_we_addr, 64'h80000010);
        check64("sd we data", last_we_data, 64'h1122334455667788);
        check64("sd we mask", 64'(last_we_mask), 64'hFF);

        // Loads from one memory word
        rd_word = 64'h0123456789ABCDEF;
        rd0 = rd_cnt;
        send(1'b0, 2'd0, 1'b1, 64'h80000013, 64'h0, w);
        bus.req_valid = 1'b0;
        collect("lb signed", 64'hFFFFFFFFFFFFFF89, 1'b0, 3, 0);
        check64("lb rd count", 64'(rd_cnt - rd0), 64'd1);
        check64("lb rd addr", last_rd_addr, 64'h80000010);
        send(1'b0, 2'd0, 1'b0, 64'h80000013, 64'h0, w);
        bus.req_valid = 1'b0;
        collect("lb unsigned", 64'h0000000000000089, 1'b0, 3, 0);
        send(1'b0, 2'd1, 1'b1, 64'h8000001A, 64'h0, w);
        bus.req_valid = 1'b0;
        collect("lh signed", 64'hFFFFFFFFFFFF89AB, 1'b0, 3, 0);
        send(1'b0, 2'd2, 1'b1, 64'h8000001C, 64'h0, w);
        bus.req_valid = 1'b0;
        collect("lw signed", 64'h0000000001234567, 1'b0, 3, 0);

        // SH
        send(1'b1, 2'd1, 1'b0, 64'h80000002, 64'h000000000000BEEF, w);
        bus.req_valid = 1'b0;
        collect("sh", 64'h0, 1'b0, 2, 0);
        check64("sh we addr", last_we_addr, 64'h80000002);
        check64("sh we data", last_we_data, 64'h000000000000BEEF);
        check64("sh we mask", 64'(last_we_mask), 64'h03);

        // Misaligned LW
        rd0 = rd_cnt;
        we0 = we_cnt;
        send(1'b0, 2'd2, 1'b1, 64'h80000002, 64'h0, w);
        bus.req_valid = 1'b0;
        collect("lw misaligned", 64'h0, 1'b1, 1, 0);
        check64("misaligned rd count", 64'(rd_cnt - rd0), 64'd0);
        check64("misaligned we count", 64'(we_cnt - we0), 64'd0);

        // Backpressure with a competing request held on the input
        rd_word = 64'hDEADBEEFCAFEF00D;
        send(1'b0, 2'd3, 1'b0, 64'h80000018, 64'h0, w);
        drive(1'b0, 2'd0, 1'b0, 64'h8000001F, 64'h0);
        collect("ld stalled", 64'hDEADBEEFCAFEF00D, 1'b0, 3, 3);
        send(1'b0, 2'd0, 1'b0, 64'h8000001F, 64'h0, w);
        bus.req_valid = 1'b0;
        check64("back-to-back accept wait", 64'(w), 64'd0);
        collect("lbu after stall", 64'h00000000000000DE, 1'b0, 3, 0);

        // Reset while waiting for read data
        rd_word = 64'h0123456789ABCDEF;
        send(1'b0, 2'd0, 1'b1, 64'h80000013, 64'h0, w);
        bus.req_valid = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check64("rd_wait reset resp_valid", 64'(bus.resp_valid), 64'd0);
        check64("rd_wait reset req_ready",  64'(bus.req_ready),  64'd0);
        check64("rd_wait reset mem_rd_en",  64'(bus.mem_rd_en),  64'd0);
        check64("rd_wait reset resp_rdata", bus.resp_rdata, 64'h0);
        #4 rst = 1'b0;
        #1 check64("rd_wait post-reset req_ready", 64'(bus.req_ready), 64'd1);
        rd0 = rd_cnt;
        repeat (4) @(posedge clk);
        #1;
        check64("no stray read after reset", 64'(rd_cnt - rd0), 64'd0);
        send(1'b0, 2'd0, 1'b0, 64'h80000013, 64'h0, w);
        bus.req_valid = 1'b0;
        collect("lbu after reset", 64'h0000000000000089, 1'b0, 3, 0);

        repeat (2) @(posedge clk);
        chk_en = 1'b0;
        #1;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
